instr_fetch: RTL and testbench

- Fetch stage of the MIPS core. It sits directly upstream of the word-addressed instruction ROM and drives its address.
- Owns the program counter and registers the ROM read data into a fetch/decode output register, with a valid/ready handshake toward decode.
- Accepts branch/jump redirects and flushes the in-flight instruction.
- ROM read is combinational (same-cycle data for a given address).

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS fetch stage.
// Owns the program counter and drives the word address of a combinational
// instruction ROM. The returned word is captured into a fetch/decode register
// that has a valid/ready handshake toward decode. A branch/jump redirect
// flushes the captured word and reloads the pc.
//
// Optional feature: define FETCH_HALT_EN to stop fetching on an all-zero
// instruction word. The stage then parks in HALT until a redirect or reset.
// With FETCH_HALT_EN undefined, zero words are delivered as ordinary NOPs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// BOOT    | one idle cycle after reset release; no load, only a redirect moves pc
// RUN     | fetching; loads whenever the output register is free or being taken
// HALT    | zero word seen (FETCH_HALT_EN only); no loads until redirect/reset

module instr_fetch #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_instr_pc,
  output logic [31:0]       o_instr_pc4
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_instr_pc4;
  logic        r_instr_valid;

  logic        w_slot_free;
  logic        w_load_cond;
  logic        w_zero_halt;
  logic        w_load;
  logic [31:0] w_pc_next;
  logic [31:0] w_redirect_target;
  logic        w_unused_redirect_lsbs;

  // The low two bits of a redirect target are dropped, so the pc stays word aligned.
  assign w_unused_redirect_lsbs = ^i_redirect_pc[1:0];
  assign w_redirect_target      = {i_redirect_pc[31:2], 2'b00};

  // pc arithmetic wraps naturally modulo 2^32.
  assign w_pc_next = r_pc + 32'd4;

  // Output register can accept a new word when empty or when decode takes it now.
  assign w_slot_free = ~r_instr_valid | i_instr_ready;
  assign w_load_cond = (r_state == ST_RUN) & w_slot_free & ~i_redirect_valid;

`ifdef FETCH_HALT_EN
  // An all-zero word is treated as a stop marker instead of being delivered.
  assign w_zero_halt = w_load_cond & (i_rom_data == 32'h0000_0000);
`else
  assign w_zero_halt = 1'b0;
`endif

  assign w_load = w_load_cond & ~w_zero_halt;

  // ROM addressing ignores pc bits above the ROM, so it wraps modulo 2^ADDR_W words.
  assign o_rom_addr = r_pc[ADDR_W+1:2];

  // Fetch sequencer: redirect first, then BOOT bubble, loads, stalls and halt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_instr_pc4   <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
    end else if (i_redirect_valid) begin
      // A handshake in this cycle still completes; the flush just drops the slot.
      r_pc          <= w_redirect_target;
      r_instr_valid <= 1'b0;
      r_state       <= ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_load) begin
            r_instr       <= i_rom_data;
            r_instr_pc    <= r_pc;
            r_instr_pc4   <= w_pc_next;
            r_instr_valid <= 1'b1;
            r_pc          <= w_pc_next;
          end else if (w_zero_halt) begin
            // pc stays on the zero word so a later redirect-free resume is impossible.
            r_instr_valid <= 1'b0;
            r_state       <= ST_HALT;
          end
        end
        ST_HALT: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
          r_state       <= ST_BOOT;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_pc4   = r_instr_pc4;
  assign o_instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed test-plan steps followed by a random
// phase, all checked against a behavioural model of the fetch rules.
module tb_instr_fetch;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;

  logic [31:0] rom [0:255];

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic        m_valid;
  logic        m_boot;
  logic        m_halt;

  instr_fetch #(.ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_instr_pc4      (instr_pc4)
  );

  assign rom_data = rom[rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_ipc   = 32'h0;
    m_ipc4  = 32'h0;
    m_valid = 1'b0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, m_valid});
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".instr_pc"}, instr_pc, m_ipc);
    chk({tag, ".instr_pc4"}, instr_pc4, m_ipc4);
    chk({tag, ".rom_addr"}, {24'b0, rom_addr}, {24'b0, m_pc[9:2]});
  endtask

  // One rising edge: update the model from the inputs held across the edge, then compare.
  task automatic step(input string tag);
    logic [31:0] w;
    @(posedge clk);
    if (redirect_valid) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_boot  = 1'b0;
      m_halt  = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt && (!m_valid || instr_ready)) begin
      w = rom[m_pc[9:2]];
      if (HALT_EN && w == 32'h0) begin
        m_valid = 1'b0;
        m_halt  = 1'b1;
      end else begin
        m_instr = w;
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom | 32'h1;
    rom[0] = 32'h20010003;
    rom[1] = 32'h20020009;
    rom[2] = 32'h00221020;
    rom[4] = 32'h00222025;
    rom[6] = 32'h00A4302A;
    rom[7] = 32'h0000_0000;

    // reset values
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b1;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // boot bubble then back-to-back delivery
    step("boot");
    chk("boot_no_valid", {31'b0, instr_valid}, 32'h0);
    step("w0");
    chk("tp_w0", instr, 32'h20010003);
    chk("tp_w0_pc4", instr_pc4, 32'h4);
    step("w1");
    chk("tp_w1", instr, 32'h20020009);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("stall");
    chk("tp_stall_instr", instr, 32'h20020009);
    chk("tp_stall_addr", {24'b0, rom_addr}, 32'h2);
    instr_ready = 1'b1;
    step("w2");
    chk("tp_w2", instr, 32'h00221020);
    chk("tp_w2_pc", instr_pc, 32'h8);

    // redirect while stalled
    instr_ready = 1'b0;
    step("stall2");
    redirect_valid = 1'b1; redirect_pc = 32'h13;
    step("redir13");
    chk("tp_redir_flush", {31'b0, instr_valid}, 32'h0);
    chk("tp_redir_addr", {24'b0, rom_addr}, 32'h4);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    step("after_redir");
    chk("tp_redir_instr", instr, 32'h00222025);
    chk("tp_redir_pc", instr_pc, 32'h10);

    // rom address wrap
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step("redir3fc");
    chk("tp_wrap_addr255", {24'b0, rom_addr}, 32'd255);
    redirect_valid = 1'b0;
    step("f3fc");
    chk("tp_wrap_ipc", instr_pc, 32'h3FC);
    step("f400");
    chk("tp_wrap_ipc400", instr_pc, 32'h400);
    chk("tp_wrap_ipc4", instr_pc4, 32'h404);

    // 32-bit pc wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step("redir_top");
    redirect_valid = 1'b0;
    step("f_top");
    chk("tp_top_pc4", instr_pc4, 32'h0);
    step("f_zero");
    chk("tp_top_next", instr_pc, 32'h0);

    // async reset pulsed mid-stall between edges
    instr_ready = 1'b0;
    step("stall3");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    #1 rst_n = 1'b1;
    instr_ready = 1'b1;
    step("boot2");
    step("refetch_w0");
    chk("tp_refetch", instr, 32'h20010003);

    // zero word at word 7
    redirect_valid = 1'b1; redirect_pc = 32'h18;
    step("redir18");
    redirect_valid = 1'b0;
    step("w6");
    chk("tp_w6", instr, 32'h00A4302A);
    step("w7");
`ifdef FETCH_HALT_EN
    chk("tp_halt_valid", {31'b0, instr_valid}, 32'h0);
    for (int i = 0; i < 4; i++) step("halted");
    chk("tp_halt_addr", {24'b0, rom_addr}, 32'h7);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step("redir_exit");
    redirect_valid = 1'b0;
    step("resume");
    chk("tp_resume", instr, 32'h20010003);
`else
    chk("tp_nop_valid", {31'b0, instr_valid}, 32'h1);
    chk("tp_nop_instr", instr, 32'h0);
    chk("tp_nop_pc", instr_pc, 32'h1C);
`endif

    // random phase
    for (int i = 0; i < 400; i++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: redirect_pc = $urandom_range(0, 63);
      endcase
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
